// File: rtl/serial_word_collector.sv
// Reassembles an LSB-first serial bit stream into WIDTH-bit words and presents
// each word on a one-entry valid/ready buffer with overrun and framing-error pulses.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_data,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] word_data_r;
  logic             word_vld_r;
  logic             overrun_r;
  logic             frame_err_r;
  logic             busy_r;

  logic             complete_s;
  logic [WIDTH-1:0] full_word_s;
  logic [WIDTH-1:0] first_bit_s;

  // Completion detect and the finished word including the bit being sampled now.
  always_comb begin
    complete_s  = 1'b0;
    full_word_s = shift_r;
    first_bit_s = {{(WIDTH-1){1'b0}}, bit_in};
    if ((state_r == SHIFT) && bit_vld && !frame_start && (cnt_r == LAST_IDX)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    full_word_s[WIDTH-1] = bit_in;
  end

  // Frame FSM, shift register and output buffer, all registered.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      shift_r     <= '0;
      word_data_r <= '0;
      word_vld_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;

      // A full buffer being popped on the completion edge takes the new word with no bubble.
      if (complete_s) begin
        if (!word_vld_r || word_rdy) begin
          word_data_r <= full_word_s;
          word_vld_r  <= 1'b1;
        end else begin
          overrun_r   <= 1'b1;
        end
      end else if (word_vld_r && word_rdy) begin
        word_vld_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (bit_vld && frame_start) begin
            shift_r <= first_bit_s;
            cnt_r   <= ONE_CNT;
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_vld) begin
            if (frame_start) begin
              frame_err_r <= 1'b1;
              shift_r     <= first_bit_s;
              cnt_r       <= ONE_CNT;
            end else if (cnt_r == LAST_IDX) begin
              shift_r <= '0;
              cnt_r   <= '0;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              shift_r[cnt_r] <= bit_in;
              cnt_r          <= cnt_r + ONE_CNT;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          shift_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign word_data = word_data_r;
  assign word_vld  = word_vld_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule
